// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order reorder buffer.
//   Allocates ROB ids at dispatch, captures execution writebacks, publishes
//   per-entry ready/data for operand wakeup, and retires one instruction per
//   cycle in program order.
//   Optional feature macro: ROB_FLUSH_EN adds a 'flush' input that discards
//   every in-flight entry (tail snaps back to head).
module reorder_buffer #(
  parameter int DEPTH  = 32,
  parameter int IDX_W  = 5,
  parameter int NUM_WB = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef ROB_FLUSH_EN
  input  logic                    flush,
`endif
  input  logic                    dispatch_valid,
  input  logic [4:0]              dispatch_rd,
  input  logic [31:0]             dispatch_pc,
  output logic                    dispatch_ready,
  output logic [IDX_W-1:0]        alloc_rob_id,
  input  logic [NUM_WB-1:0]       wb_valid,
  input  logic [NUM_WB*IDX_W-1:0] wb_rob_id,
  input  logic [NUM_WB*32-1:0]    wb_data,
  output logic [DEPTH-1:0]        rob_ready,
  output logic [DEPTH*32-1:0]     rob_rd_data,
  output logic                    commit_valid,
  output logic [IDX_W-1:0]        commit_rob_id,
  output logic [4:0]              commit_rd,
  output logic [31:0]             commit_data,
  output logic [31:0]             commit_pc,
  output logic                    rob_empty
);

  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  // Pointers carry one extra wrap bit above the index.
  logic [IDX_W:0]       head;
  logic [IDX_W:0]       tail;
  logic [IDX_W-1:0]     head_idx;
  logic [IDX_W-1:0]     tail_idx;

  logic [DEPTH-1:0]     ent_valid;
  logic [DEPTH-1:0]     ent_ready;
  logic [RD_W-1:0]      ent_rd   [DEPTH];
  logic [DATA_W-1:0]    ent_pc   [DEPTH];
  logic [DATA_W-1:0]    ent_data [DEPTH];

  logic                 full;
  logic                 flush_now;
  logic                 do_alloc;
  logic                 do_commit;

  logic [DEPTH-1:0]     wb_we;
  logic [DATA_W-1:0]    wb_wdata [DEPTH];

`ifdef ROB_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  assign head_idx = head[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  assign full      = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
  assign rob_empty = (head == tail);

  // A full ROB does not look ahead at a same-cycle retire; dispatch waits a cycle.
  assign dispatch_ready = !full;
  assign alloc_rob_id   = tail_idx;
  assign do_alloc       = dispatch_valid && !full && !flush_now;

  assign commit_valid  = ent_valid[head_idx] && ent_ready[head_idx] && !flush_now;
  assign do_commit     = commit_valid;
  assign commit_rob_id = head_idx;
  assign commit_rd     = ent_rd[head_idx];
  assign commit_data   = ent_data[head_idx];
  assign commit_pc     = ent_pc[head_idx];

  // Decode writeback ports per entry; scanning high to low lets port 0 win a conflict.
  always_comb begin
    wb_we = '0;
    for (int e = 0; e < DEPTH; e++) begin
      wb_wdata[e] = '0;
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (wb_valid[p] && (wb_rob_id[p*IDX_W +: IDX_W] == IDX_W'(e)) &&
            ent_valid[e] && !flush_now) begin
          wb_we[e]    = 1'b1;
          wb_wdata[e] = wb_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Head/tail pointer update; the extra MSB toggles naturally on wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (do_commit) begin
        head <= head + (IDX_W+1)'(1);
      end
      if (flush_now) begin
        tail <= head;
      end else if (do_alloc) begin
        tail <= tail + (IDX_W+1)'(1);
      end
    end
  end

  // Per-entry state: flush, then retire-clear, then allocate, then writeback capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_ready <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        ent_rd[e]   <= '0;
        ent_pc[e]   <= '0;
        ent_data[e] <= '0;
      end
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (flush_now) begin
          ent_valid[e] <= 1'b0;
          ent_ready[e] <= 1'b0;
          ent_data[e]  <= '0;
        end else if (do_commit && (head_idx == IDX_W'(e))) begin
          ent_valid[e] <= 1'b0;
          ent_ready[e] <= 1'b0;
          ent_data[e]  <= '0;
        end else if (do_alloc && (tail_idx == IDX_W'(e))) begin
          // The tail entry is never valid when not full, so no writeback can collide here.
          ent_valid[e] <= 1'b1;
          ent_ready[e] <= 1'b0;
          ent_rd[e]    <= dispatch_rd;
          ent_pc[e]    <= dispatch_pc;
          ent_data[e]  <= '0;
        end else if (wb_we[e]) begin
          ent_ready[e] <= 1'b1;
          ent_data[e]  <= wb_wdata[e];
        end
      end
    end
  end

  // Publish registered per-entry status for reservation-station wakeup.
  always_comb begin
    rob_ready   = '0;
    rob_rd_data = '0;
    for (int e = 0; e < DEPTH; e++) begin
      rob_ready[e]                  = ent_valid[e] & ent_ready[e];
      rob_rd_data[e*DATA_W +: DATA_W] = ent_data[e];
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed bench for reorder_buffer.
module tb_reorder_buffer;

  localparam int DEPTH  = 32;
  localparam int IDX_W  = 5;
  localparam int NUM_WB = 2;

  logic                    clk;
  logic                    rst_n;
  logic                    flush;
  logic                    dispatch_valid;
  logic [4:0]              dispatch_rd;
  logic [31:0]             dispatch_pc;
  logic                    dispatch_ready;
  logic [IDX_W-1:0]        alloc_rob_id;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*IDX_W-1:0] wb_rob_id;
  logic [NUM_WB*32-1:0]    wb_data;
  logic [DEPTH-1:0]        rob_ready;
  logic [DEPTH*32-1:0]     rob_rd_data;
  logic                    commit_valid;
  logic [IDX_W-1:0]        commit_rob_id;
  logic [4:0]              commit_rd;
  logic [31:0]             commit_data;
  logic [31:0]             commit_pc;
  logic                    rob_empty;

  int checks;
  int failures;

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_WB(NUM_WB)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef ROB_FLUSH_EN
    .flush          (flush),
`endif
    .dispatch_valid (dispatch_valid),
    .dispatch_rd    (dispatch_rd),
    .dispatch_pc    (dispatch_pc),
    .dispatch_ready (dispatch_ready),
    .alloc_rob_id   (alloc_rob_id),
    .wb_valid       (wb_valid),
    .wb_rob_id      (wb_rob_id),
    .wb_data        (wb_data),
    .rob_ready      (rob_ready),
    .rob_rd_data    (rob_rd_data),
    .commit_valid   (commit_valid),
    .commit_rob_id  (commit_rob_id),
    .commit_rd      (commit_rd),
    .commit_data    (commit_data),
    .commit_pc      (commit_pc),
    .rob_empty      (rob_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asserted away from the clock edge; released one cycle later.
  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic set_wb(input int port, input logic [4:0] id, input logic [31:0] d);
    wb_valid[port]            = 1'b1;
    wb_rob_id[port*IDX_W +: IDX_W] = id;
    wb_data[port*32 +: 32]    = d;
  endtask

  task automatic clr_wb();
    wb_valid  = '0;
    wb_rob_id = '0;
    wb_data   = '0;
  endtask

  task automatic dispatch(input logic [4:0] rd, input logic [31:0] pc);
    dispatch_valid = 1'b1;
    dispatch_rd    = rd;
    dispatch_pc    = pc;
    tick();
    dispatch_valid = 1'b0;
  endtask

  function automatic logic [31:0] rdata(input int id);
    return rob_rd_data[id*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b1;
    flush = 1'b0;
    dispatch_valid = 1'b0;
    dispatch_rd = '0;
    dispatch_pc = '0;
    clr_wb();

    // ---- reset then idle: async reset visible before any clock edge
    #3 rst_n = 1'b0;
    #1;
    chk("rst_dispatch_ready", dispatch_ready, 1);
    chk("rst_empty", rob_empty, 1);
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_alloc_id", alloc_rob_id, 0);
    chk("rst_rob_ready", rob_ready, 0);
    chk("rst_commit_data", commit_data, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- in-order retire
    dispatch(5'd1, 32'h100);
    chk("io_alloc_after1", alloc_rob_id, 1);
    dispatch(5'd2, 32'h104);
    dispatch(5'd3, 32'h108);
    chk("io_alloc_after3", alloc_rob_id, 3);
    chk("io_not_empty", rob_empty, 0);
    chk("io_no_commit", commit_valid, 0);
    set_wb(0, 5'd2, 32'h33);
    chk("io_wb_latency", rob_ready[2], 0);
    tick();
    chk("io_ready2", rob_ready[2], 1);
    chk("io_data2", rdata(2), 32'h33);
    chk("io_no_commit_ooo", commit_valid, 0);
    clr_wb(); set_wb(0, 5'd1, 32'h22);
    tick();
    clr_wb(); set_wb(0, 5'd0, 32'h11);
    tick();
    clr_wb();
    chk("io_c0_valid", commit_valid, 1);
    chk("io_c0_id", commit_rob_id, 0);
    chk("io_c0_rd", commit_rd, 1);
    chk("io_c0_data", commit_data, 32'h11);
    chk("io_c0_pc", commit_pc, 32'h100);
    tick();
    chk("io_c1_valid", commit_valid, 1);
    chk("io_c1_rd", commit_rd, 2);
    chk("io_c1_data", commit_data, 32'h22);
    chk("io_c1_pc", commit_pc, 32'h104);
    tick();
    chk("io_c2_valid", commit_valid, 1);
    chk("io_c2_id", commit_rob_id, 2);
    chk("io_c2_rd", commit_rd, 3);
    chk("io_c2_data", commit_data, 32'h33);
    tick();
    chk("io_done_valid", commit_valid, 0);
    chk("io_done_empty", rob_empty, 1);
    chk("io_done_ready", rob_ready, 0);

    // ---- full and wrap
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      dispatch(5'(i), 32'h1000 + 32'(i * 4));
    end
    chk("full_ready", dispatch_ready, 0);
    chk("full_alloc_id", alloc_rob_id, 0);
    chk("full_not_empty", rob_empty, 0);
    dispatch_valid = 1'b1; dispatch_rd = 5'd7; dispatch_pc = 32'hDEAD;
    tick();
    chk("full_ignored_ready", dispatch_ready, 0);
    chk("full_ignored_alloc", alloc_rob_id, 0);
    set_wb(1, 5'd0, 32'h55);
    tick();
    clr_wb();
    chk("full_c0_valid", commit_valid, 1);
    chk("full_c0_rd_zero", commit_rd, 0);
    chk("full_c0_pc", commit_pc, 32'h1000);
    chk("full_c0_data", commit_data, 32'h55);
    chk("full_stall_while_retire", dispatch_ready, 0);
    dispatch_rd = 5'd9; dispatch_pc = 32'h2000;
    tick();
    chk("wrap_ready", dispatch_ready, 1);
    chk("wrap_alloc_id", alloc_rob_id, 0);
    chk("wrap_no_commit", commit_valid, 0);
    chk("wrap_head_id", commit_rob_id, 1);
    tick();
    dispatch_valid = 1'b0;
    chk("wrap_full_again", dispatch_ready, 0);
    chk("wrap_alloc_next", alloc_rob_id, 1);
    chk("wrap_ready0_clear", rob_ready[0], 0);
    chk("wrap_data0_clear", rdata(0), 0);

    // ---- asynchronous reset in the middle of operation
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_empty", rob_empty, 1);
    chk("midrst_dispatch_ready", dispatch_ready, 1);
    chk("midrst_rob_ready", rob_ready, 0);
    chk("midrst_alloc", alloc_rob_id, 0);
    chk("midrst_commit_rd", commit_rd, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ---- writeback port conflict, invalid target, overwrite
    for (int i = 0; i < 6; i++) dispatch(5'(i + 10), 32'h300 + 32'(i * 4));
    set_wb(0, 5'd5, 32'hAAAA);
    set_wb(1, 5'd5, 32'hBBBB);
    tick();
    clr_wb();
    chk("conf_ready5", rob_ready[5], 1);
    chk("conf_data5", rdata(5), 32'hAAAA);
    set_wb(0, 5'd9, 32'h99);
    set_wb(1, 5'd3, 32'h3333);
    tick();
    clr_wb();
    chk("inv_ready9", rob_ready[9], 0);
    chk("inv_data9", rdata(9), 0);
    chk("p1_ready3", rob_ready[3], 1);
    chk("p1_data3", rdata(3), 32'h3333);
    set_wb(0, 5'd5, 32'hCCCC);
    tick();
    clr_wb();
    chk("ovw_data5", rdata(5), 32'hCCCC);
    chk("conf_no_commit", commit_valid, 0);

    // ---- concurrent allocate, writeback and commit
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(5'(i + 1), 32'h400 + 32'(i * 4));
    set_wb(0, 5'd0, 32'h10);
    tick();
    clr_wb();
    chk("cc_head_ready", commit_valid, 1);
    dispatch_valid = 1'b1; dispatch_rd = 5'd5; dispatch_pc = 32'h410;
    set_wb(1, 5'd2, 32'h22);
    tick();
    dispatch_valid = 1'b0;
    clr_wb();
    chk("cc_alloc_id", alloc_rob_id, 5);
    chk("cc_head_id", commit_rob_id, 1);
    chk("cc_no_commit", commit_valid, 0);
    chk("cc_ready2", rob_ready[2], 1);
    chk("cc_ready0_clear", rob_ready[0], 0);
    chk("cc_data0_clear", rdata(0), 0);
    chk("cc_ready4_new", rob_ready[4], 0);

`ifdef ROB_FLUSH_EN
    // ---- flush discards everything; tail returns to head
    do_reset();
    dispatch(5'd1, 32'h500);
    dispatch(5'd2, 32'h504);
    set_wb(0, 5'd0, 32'h1);
    set_wb(1, 5'd1, 32'h2);
    tick();
    clr_wb();
    tick();
    tick();
    chk("fl_pre_empty", rob_empty, 1);
    for (int i = 0; i < 6; i++) dispatch(5'(i + 3), 32'h600 + 32'(i * 4));
    set_wb(0, 5'd2, 32'h77);
    tick();
    chk("fl_pre_commit", commit_valid, 1);
    flush = 1'b1;
    dispatch_valid = 1'b1; dispatch_rd = 5'd20; dispatch_pc = 32'h700;
    set_wb(0, 5'd3, 32'h9);
    #1;
    chk("fl_commit_blocked", commit_valid, 0);
    tick();
    flush = 1'b0;
    dispatch_valid = 1'b0;
    clr_wb();
    chk("fl_empty", rob_empty, 1);
    chk("fl_no_commit", commit_valid, 0);
    chk("fl_alloc_old_head", alloc_rob_id, 2);
    chk("fl_rob_ready", rob_ready, 0);
    chk("fl_dispatch_ready", dispatch_ready, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer between decode/dispatch and the reservation stations.
- Allocates a destination ROB id for each dispatched instruction and captures execution-unit writebacks.
- Publishes per-entry ready/data so reservation stations can resolve pending operands by ROB id.
- Retires completed instructions in program order to the architectural register file, one per cycle.

Parameters:
- DEPTH, 32, number of ROB entries; power of two.
- IDX_W, 5, ROB id width; equals log2(DEPTH).
- NUM_WB, 2, number of execution writeback ports.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dispatch_valid  input  1  decode presents an instruction for allocation.
- dispatch_rd  input  5  architectural destination register.
- dispatch_pc  input  32  instruction PC, carried to commit.
- dispatch_ready  output  1  ROB can accept an allocation this cycle.
- alloc_rob_id  output  IDX_W  id that the current allocation receives (tail index).
- wb_valid  input  NUM_WB  per-port writeback strobe.
- wb_rob_id  input  NUM_WB*IDX_W  per-port target ROB id.
- wb_data  input  NUM_WB*32  per-port result.
- rob_ready  output  DEPTH  per-entry result-ready bit (entry valid and written back).
- rob_rd_data  output  DEPTH*32  per-entry result value.
- commit_valid  output  1  head entry retires this cycle.
- commit_rob_id  output  IDX_W  id of the retiring entry.
- commit_rd  output  5  destination register of the retiring entry.
- commit_data  output  32  result of the retiring entry.
- commit_pc  output  32  PC of the retiring entry.
- rob_empty  output  1  no valid entries.

Behaviour:
- State:
  - head and tail pointers, each IDX_W+1 bits; the MSB is the wrap bit.
  - Per entry: valid, ready, rd, pc, data.
- Full/empty:
  - full when the index bits are equal and the wrap bits differ.
  - empty when the pointers are fully equal.
  - dispatch_ready = !full. It does not account for a same-cycle commit, so a full ROB stalls dispatch for one cycle even while retiring.
- Allocate (dispatch_valid && dispatch_ready):
  - Entry[tail] gets valid=1, ready=0, rd, pc.
  - tail increments, wrapping at DEPTH and toggling the wrap bit.
  - alloc_rob_id = tail[IDX_W-1:0] combinationally, and is valid even when no allocation occurs.
  - dispatch_valid while full is ignored, with no state change.
- Writeback:
  - For each port with wb_valid set and a valid target entry, set ready=1 and store data. Visible on rob_ready/rob_rd_data the next cycle (1-cycle latency, no combinational bypass).
  - Writeback to an invalid entry is ignored.
  - Two ports targeting the same id in one cycle: lowest port index wins.
  - Writeback to an already-ready entry overwrites data.
- Commit:
  - commit_valid = entry[head].valid && entry[head].ready, combinationally.
  - The commit_* fields come from entry[head].
  - On commit, the entry is cleared (valid=0, ready=0, data=0) and head increments with wrap.
  - rd=0 commits normally; the register file discards x0 writes.
- Simultaneous events:
  - Allocate, commit and writebacks may all occur in one cycle; each acts independently.
  - Writeback to the head entry in cycle N allows commit in cycle N+1 at the earliest.
  - Allocate into an index being committed the same cycle cannot occur, because the ROB is full in that case.
- Reset:
  - Asynchronous, takes effect immediately, including mid-operation; all in-flight entries are discarded.
  - Every entry: valid=0, ready=0, data=0.
  - head=tail=0.
  - Outputs: dispatch_ready=1, alloc_rob_id=0, rob_ready=0, rob_rd_data=0, commit_valid=0, commit_* fields=0, rob_empty=1.

Optional Feature:
- Macro: ROB_FLUSH_EN.
- With the macro defined:
  - Adds input flush (1 bit).
  - When flush is high at a clock edge: all entries are invalidated and tail is set to head.
  - commit_valid is forced 0 in that cycle.
  - Allocations and writebacks in the flush cycle are dropped.
- Without the macro: no flush port; entries leave only by commit or reset.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> immediately dispatch_ready=1, rob_empty=1, commit_valid=0, alloc_rob_id=0.
- In-order retire: dispatch rd=1,2,3 (ids 0,1,2); writeback id2=0x33, id1=0x22, id0=0x11 on consecutive cycles -> commits in order: rd1/0x11, rd2/0x22, rd3/0x33 on three consecutive cycles.
- Full and wrap: dispatch 32 entries -> dispatch_ready=0 and alloc_rob_id=0. Write back and commit id0; dispatch next -> receives id0 with wrap bit toggled, and rob_ready[0]=0.
- Port conflict: port0 and port1 both write id5 with 0xAAAA and 0xBBBB in the same cycle -> rob_rd_data[5]=0xAAAA and rob_ready[5]=1 the next cycle. Writeback to unallocated id9 -> rob_ready[9] stays 0.
- Concurrent: with 4 entries and the head ready, dispatch, writeback id2 and commit in the same cycle -> count stays 4, head advances, rob_ready[2]=1 the next cycle.
- ROB_FLUSH_EN: 6 entries in flight, pulse flush -> rob_empty=1 the next cycle, no commit_valid, and the next allocation gets id = old head.
